// File: rtl/sha512_pkg.sv
// sha512_pkg
// Shared constants and types for the SHA-512 message front end.
//   CHUNK_W   : width of one compressor chunk (16 words of 64 bits)
//   WORD_W    : width of one message word / input beat
//   LEN_W     : width of the trailing message bit-length field
//   PAD_BYTE  : marker byte that terminates the message
//   state_t   : padder FSM states
//   clamp_bytes : limits a final-beat byte count to 0..8
package sha512_pkg;

  localparam int CHUNK_W = 1024;
  localparam int WORD_W  = 64;
  localparam int LEN_W   = 128;
  localparam int WORDS   = CHUNK_W / WORD_W;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    FILL,
    SEND,
    PAD,
    SEND_PAD,
    SEND_LEN
  } state_t;

  // Byte counts above a full word are treated as a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
    return (b > 4'd8) ? 4'd8 : b;
  endfunction

endpackage

// File: rtl/sha512_pad_word.sv
// sha512_pad_word
// Combinational padding of the final message word: keeps the first
// nbytes bytes (big-endian, first byte in [63:56]), inserts the 0x80
// marker right after them when the word is not full, zeroes the rest.
//   data   : raw final beat
//   nbytes : valid byte count, already clamped to 0..8
//   word   : masked and marked word
module sha512_pad_word
  import sha512_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [3:0]        nbytes,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) begin
        word[WORD_W-1-8*b -: 8] = data[WORD_W-1-8*b -: 8];
      end else if (4'(b) == nbytes) begin
        word[WORD_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// sha512_padder
// SHA-512 message front end. Collects big-endian 64-bit beats into a
// single 1024-bit chunk buffer, applies the 0x80 marker, zero fill and
// the 128-bit bit length, and hands chunks to the compressor.
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/ready  : input beat handshake
//   in_data         : 8 message bytes, first byte in [63:56]
//   in_last         : final beat of the message
//   in_bytes        : valid bytes of the final beat (left-justified)
//   chunk_valid/ready : output chunk handshake
//   chunk           : padded chunk, word 0 in [1023:960]
//   chunk_first     : first chunk of a message
//   chunk_last      : final chunk of a message
module sha512_padder
  import sha512_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [3:0]         in_bytes,
  output logic               chunk_valid,
  input  logic               chunk_ready,
  output logic [CHUNK_W-1:0] chunk,
  output logic               chunk_first,
  output logic               chunk_last
);

  // Word w of the chunk lives at buf[WORDS-1-w] so that the packed
  // buffer maps directly onto the output bit layout.
  logic [WORDS-1:0][WORD_W-1:0] buf_q, buf_d;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;     // full chunk closed the message
  logic             extra_q, extra_d;   // length needs its own chunk
  logic             carry_q, carry_d;   // 0x80 belongs in word idx+1
  logic             fits_q, fits_d;     // length fits in words 14..15

  logic [3:0]        nb;
  logic [7:0]        m;
  logic [WORD_W-1:0] last_word;
  logic [LEN_W-1:0]  bit_len;
  logic              accept;
  logic              fire;

  assign in_ready    = (state_q == FILL);
  assign chunk_valid = (state_q == SEND) || (state_q == SEND_PAD) ||
                       (state_q == SEND_LEN);
  assign chunk       = buf_q;
  assign chunk_first = first_q;
  assign chunk_last  = last_q;

  assign accept  = in_valid && in_ready;
  assign fire    = chunk_valid && chunk_ready;
  assign nb      = clamp_bytes(in_bytes);
  assign m       = {1'b0, idx_q, 3'b000} + {4'b0000, nb};
  assign bit_len = LEN_W'({count_q, 3'b000});

  sha512_pad_word u_pad_word (
    .data   (in_data),
    .nbytes (nb),
    .word   (last_word)
  );

  // State and datapath registers; reset discards any partial message
  // and any chunk that was still waiting for the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      extra_q <= 1'b0;
      carry_q <= 1'b0;
      fits_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      first_q <= first_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      extra_q <= extra_d;
      carry_q <= carry_d;
      fits_q  <= fits_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and buffer update. Everything holds by default so the
  // presented chunk and flags stay stable under backpressure.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    first_d = first_q;
    last_d  = last_q;
    pend_d  = pend_q;
    extra_d = extra_q;
    carry_d = carry_q;
    fits_d  = fits_q;
    buf_d   = buf_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (!in_last) begin
            buf_d[4'd15 - idx_q] = in_data;
            idx_d   = idx_q + 4'd1;
            count_d = count_q + CNT_W'(8);
            if (idx_q == 4'd15) begin
              state_d = SEND;
              last_d  = 1'b0;
              pend_d  = 1'b0;
            end
          end else begin
            buf_d[4'd15 - idx_q] = last_word;
            count_d = count_q + CNT_W'(nb);
            carry_d = (nb == 4'd8);
            fits_d  = (m <= 8'd111);
            if (m == 8'd128) begin
              state_d = SEND;
              pend_d  = 1'b1;
              last_d  = 1'b0;
            end else begin
              state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        for (int w = 0; w < WORDS; w++) begin
          if (4'(w) > idx_q) begin
            buf_d[WORDS-1-w] = '0;
            if (carry_q && (4'(w) == idx_q + 4'd1)) begin
              buf_d[WORDS-1-w] = {PAD_BYTE, 56'b0};
            end
          end
        end
        if (fits_q) begin
          buf_d[1:0] = bit_len;
          last_d     = 1'b1;
          extra_d    = 1'b0;
        end else begin
          last_d     = 1'b0;
          extra_d    = 1'b1;
        end
        state_d = SEND_PAD;
      end

      // A message that exactly filled the chunk still owes a chunk
      // holding the marker and the length.
      SEND: begin
        if (fire) begin
          first_d = 1'b0;
          idx_d   = '0;
          if (pend_q) begin
            buf_d         = '0;
            buf_d[WORDS-1] = {PAD_BYTE, 56'b0};
            buf_d[1:0]    = bit_len;
            last_d        = 1'b1;
            pend_d        = 1'b0;
            state_d       = SEND_LEN;
          end else begin
            state_d = FILL;
          end
        end
      end

      SEND_PAD: begin
        if (fire) begin
          first_d = 1'b0;
          if (extra_q) begin
            buf_d      = '0;
            buf_d[1:0] = bit_len;
            last_d     = 1'b1;
            extra_d    = 1'b0;
            state_d    = SEND_LEN;
          end else begin
            count_d = '0;
            idx_d   = '0;
            first_d = 1'b1;
            state_d = FILL;
          end
        end
      end

      SEND_LEN: begin
        if (fire) begin
          count_d = '0;
          idx_d   = '0;
          first_d = 1'b1;
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_sha512_padder.sv
// tb_sha512_padder
// Directed scoreboard bench for sha512_padder: expected chunks are
// queued when a message is sent, a monitor pops and compares them on
// every accepted chunk.
module tb_sha512_padder;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          chunk_valid;
  logic          chunk_ready;
  logic [1023:0] chunk;
  logic          chunk_first;
  logic          chunk_last;

  typedef struct packed {
    logic [15:0][63:0] w;   // w[i] is message word i
    logic              first;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   nchunk   = 0;

  sha512_padder #(.CNT_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk       (chunk),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dutWord(input int w);
    return chunk[1023-64*w -: 64];
  endfunction

  function automatic logic [63:0] beatVal(input int i);
    return {16'hC0DE, 16'(i), 32'h01234567 + 32'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timeout waiting for DUT", name);
  endtask

  // Drive one beat; returns at posedge+1 after the DUT took it.
  task automatic applyStimulus(input logic [63:0] data, input logic last,
                               input logic [3:0] bytes);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_bytes = bytes;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    failTimeout("beat_accept");
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait until every expected chunk was seen and the DUT is idle.
  task automatic waitIdle(input string name);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && in_ready) return;
    end
    failTimeout(name);
    sb.delete();
  endtask

  // Monitor: a chunk is transferred on the posedge following a negedge
  // where valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && chunk_valid && chunk_ready) begin
        if (sb.size() == 0) begin
          failTimeout("unexpected_chunk");
        end else begin
          e = sb.pop_front();
          for (int w = 0; w < 16; w++)
            checkOutput($sformatf("chunk%0d_w%0d", nchunk, w), dutWord(w), e.w[w]);
          checkOutput($sformatf("chunk%0d_first", nchunk), 64'(chunk_first), 64'(e.first));
          checkOutput($sformatf("chunk%0d_last", nchunk), 64'(chunk_last), 64'(e.last));
        end
        nchunk++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t abcExp();
    exp_t e;
    e = '0;
    e.w[0]  = 64'h6162638000000000;
    e.w[15] = 64'h18;
    e.first = 1'b1;
    e.last  = 1'b1;
    return e;
  endfunction

  initial begin
    exp_t e;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    in_bytes    = '0;
    chunk_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 64'(chunk_valid), 64'd0);
    checkOutput("rst_last", 64'(chunk_last), 64'd0);
    checkOutput("rst_first", 64'(chunk_first), 64'd1);
    checkOutput("rst_word0", dutWord(0), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // "abc" with latency check: PAD cycle, then chunk valid
    sb.push_back(abcExp());
    applyStimulus(64'h6162630000000000, 1'b1, 4'd3);
    @(negedge clk);
    checkOutput("lat_pad_valid", 64'(chunk_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_send_valid", 64'(chunk_valid), 64'd1);
    waitIdle("abc_done");

    // empty message
    e = '0;
    e.w[0] = 64'h8000000000000000;
    e.first = 1'b1;
    e.last  = 1'b1;
    sb.push_back(e);
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd0);
    waitIdle("empty_done");

    // 112 bytes: length spills into a second chunk
    e = '0;
    for (int i = 0; i < 14; i++) e.w[i] = beatVal(i);
    e.w[14] = 64'h8000000000000000;
    e.first = 1'b1;
    e.last  = 1'b0;
    sb.push_back(e);
    e = '0;
    e.w[15] = 64'h380;
    e.first = 1'b0;
    e.last  = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 14; i++)
      applyStimulus(beatVal(i), (i == 13), 4'd8);
    waitIdle("b112_done");

    // 128 bytes: full data chunk then marker + length chunk
    e = '0;
    for (int i = 0; i < 16; i++) e.w[i] = beatVal(100 + i);
    e.first = 1'b1;
    e.last  = 1'b0;
    sb.push_back(e);
    e = '0;
    e.w[0]  = 64'h8000000000000000;
    e.w[15] = 64'h400;
    e.first = 1'b0;
    e.last  = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 16; i++)
      applyStimulus(beatVal(100 + i), (i == 15), 4'd8);
    waitIdle("b128_done");

    // in_bytes above 8 behaves as a full word
    e = '0;
    e.w[0]  = 64'h1122334455667788;
    e.w[1]  = 64'h8000000000000000;
    e.w[15] = 64'h40;
    e.first = 1'b1;
    e.last  = 1'b1;
    sb.push_back(e);
    applyStimulus(64'h1122334455667788, 1'b1, 4'd15);
    waitIdle("clamp_done");

    // backpressure on "abc"
    chunk_ready = 1'b0;
    sb.push_back(abcExp());
    applyStimulus(64'h6162630000000000, 1'b1, 4'd3);
    for (int c = 0; c < 10 && !chunk_valid; c++) @(negedge clk);
    if (!chunk_valid) failTimeout("bp_valid");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp%0d_valid", k), 64'(chunk_valid), 64'd1);
      checkOutput($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      checkOutput($sformatf("bp%0d_w0", k), dutWord(0), 64'h6162638000000000);
      checkOutput($sformatf("bp%0d_w15", k), dutWord(15), 64'h18);
      checkOutput($sformatf("bp%0d_first", k), 64'(chunk_first), 64'd1);
      checkOutput($sformatf("bp%0d_last", k), 64'(chunk_last), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chunk_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_valid", 64'(chunk_valid), 64'd0);
    waitIdle("bp_done");

    // reset in the middle of a message, then "abc" again
    for (int i = 0; i < 5; i++) applyStimulus(beatVal(200 + i), 1'b0, 4'd8);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(chunk_valid), 64'd0);
    checkOutput("midrst_first", 64'(chunk_first), 64'd1);
    checkOutput("midrst_last", 64'(chunk_last), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(abcExp());
    applyStimulus(64'h6162630000000000, 1'b1, 4'd3);
    waitIdle("midrst_done");

    repeat (3) @(posedge clk);
    $display("[TB] chunks observed: %0d", nchunk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
